// File: rtl/axi_node_pkg.sv
// Shared types and constants for the AXI fan-in/fan-out tree nodes.
// resp_beat_t matches the default node widths (32-bit aux, 17-bit routed ID).
package axi_node_pkg;
    localparam int SKID_DEPTH    = 2;
    localparam int AUX_WIDTH_DEF = 32;
    localparam int ID_WIDTH_DEF  = 17;

    typedef enum logic {BURST_IDLE, BURST_ACTIVE} burst_state_t;

    typedef struct packed {
        logic [AUX_WIDTH_DEF-1:0] aux;
        logic [ID_WIDTH_DEF-2:0]  id;
        logic                     last;
    } resp_beat_t;
endpackage

// File: rtl/axi_resp_skid_buf.sv
// Two-entry skid FIFO: head drives the outputs directly, 1 cycle accept-to-valid, no bypass.
// in_gnt depends only on the registered count, so it never waits on out_gnt.
module axi_resp_skid_buf
    import axi_node_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_req,
    input  logic [WIDTH-1:0] in_dat,
    output logic             in_gnt,
    output logic             out_req,
    output logic [WIDTH-1:0] out_dat,
    input  logic             out_gnt
);
    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic             wptr;
    logic             rptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    // The full check uses the pre-pop count, so a full buffer refuses input even while draining.
    assign in_gnt  = ~rst & (count < 2'(SKID_DEPTH));
    assign out_req = ~rst & (count != 2'd0);
    assign out_dat = rst ? '0 : mem[rptr];
    assign push    = in_req & in_gnt;
    assign pop     = out_req & out_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= in_dat;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/axi_fanout_primitive_resp.sv
// Steers an upstream response stream to one of two initiators by the ID MSB, which is stripped.
// Bursts stay locked to their first beat's output until LAST; a route change mid-burst flags proto_err_o.
module axi_fanout_primitive_resp
    import axi_node_pkg::*;
#(
    parameter int AUX_WIDTH = AUX_WIDTH_DEF,
    parameter int ID_WIDTH  = ID_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_req_i,
    input  logic [AUX_WIDTH-1:0] data_AUX_i,
    input  logic [ID_WIDTH-1:0]  data_ID_i,
    input  logic                 data_last_i,
    output logic                 data_gnt_o,
    output logic                 data_req0_o,
    output logic [AUX_WIDTH-1:0] data_AUX0_o,
    output logic [ID_WIDTH-2:0]  data_ID0_o,
    output logic                 data_last0_o,
    input  logic                 data_gnt0_i,
    output logic                 data_req1_o,
    output logic [AUX_WIDTH-1:0] data_AUX1_o,
    output logic [ID_WIDTH-2:0]  data_ID1_o,
    output logic                 data_last1_o,
    input  logic                 data_gnt1_i,
    output logic                 proto_err_o
);
    typedef struct packed {
        logic [AUX_WIDTH-1:0] aux;
        logic [ID_WIDTH-2:0]  id;
        logic                 last;
    } beat_t;

    burst_state_t state;
    logic         burst_dest;
    logic         route_bit;
    logic         dest;
    logic         accept;
    logic         gnt_b0;
    logic         gnt_b1;
    beat_t        in_beat;
    beat_t        out0;
    beat_t        out1;

    assign route_bit  = data_ID_i[ID_WIDTH-1];
    assign dest       = (state == BURST_ACTIVE) ? burst_dest : route_bit;
    assign data_gnt_o = dest ? gnt_b1 : gnt_b0;
    assign accept     = data_req_i & data_gnt_o;
    assign in_beat    = '{aux: data_AUX_i, id: data_ID_i[ID_WIDTH-2:0], last: data_last_i};

    axi_resp_skid_buf #(.WIDTH($bits(beat_t))) u_buf0 (
        .clk     (clk),
        .rst     (rst),
        .in_req  (data_req_i & ~dest),
        .in_dat  (in_beat),
        .in_gnt  (gnt_b0),
        .out_req (data_req0_o),
        .out_dat (out0),
        .out_gnt (data_gnt0_i)
    );

    axi_resp_skid_buf #(.WIDTH($bits(beat_t))) u_buf1 (
        .clk     (clk),
        .rst     (rst),
        .in_req  (data_req_i & dest),
        .in_dat  (in_beat),
        .in_gnt  (gnt_b1),
        .out_req (data_req1_o),
        .out_dat (out1),
        .out_gnt (data_gnt1_i)
    );

    assign data_AUX0_o  = out0.aux;
    assign data_ID0_o   = out0.id;
    assign data_last0_o = out0.last;
    assign data_AUX1_o  = out1.aux;
    assign data_ID1_o   = out1.id;
    assign data_last1_o = out1.last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BURST_IDLE;
            burst_dest  <= 1'b0;
            proto_err_o <= 1'b0;
        end else if (accept) begin
            case (state)
                BURST_IDLE: begin
                    if (!data_last_i) begin
                        state      <= BURST_ACTIVE;
                        burst_dest <= route_bit;
                    end
                end
                default: begin
                    if (route_bit != burst_dest) proto_err_o <= 1'b1;
                    if (data_last_i) state <= BURST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_fanout_primitive_resp.sv
// Directed bench for the response fan-out node: routing, bursts, skid buffering, stalls, errors and reset.
module tb_axi_fanout_primitive_resp;
    logic        clk = 1'b0;
    logic        rst;
    logic        data_req_i;
    logic [31:0] data_AUX_i;
    logic [16:0] data_ID_i;
    logic        data_last_i;
    logic        data_gnt_o;
    logic        data_req0_o, data_last0_o, data_gnt0_i;
    logic        data_req1_o, data_last1_o, data_gnt1_i;
    logic [31:0] data_AUX0_o, data_AUX1_o;
    logic [15:0] data_ID0_o, data_ID1_o;
    logic        proto_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_fanout_primitive_resp #(.AUX_WIDTH(32), .ID_WIDTH(17)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_req_i   (data_req_i),
        .data_AUX_i   (data_AUX_i),
        .data_ID_i    (data_ID_i),
        .data_last_i  (data_last_i),
        .data_gnt_o   (data_gnt_o),
        .data_req0_o  (data_req0_o),
        .data_AUX0_o  (data_AUX0_o),
        .data_ID0_o   (data_ID0_o),
        .data_last0_o (data_last0_o),
        .data_gnt0_i  (data_gnt0_i),
        .data_req1_o  (data_req1_o),
        .data_AUX1_o  (data_AUX1_o),
        .data_ID1_o   (data_ID1_o),
        .data_last1_o (data_last1_o),
        .data_gnt1_i  (data_gnt1_i),
        .proto_err_o  (proto_err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic [16:0] id, input logic [31:0] aux, input logic last);
        data_req_i  = req;
        data_ID_i   = id;
        data_AUX_i  = aux;
        data_last_i = last;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; data_gnt0_i = 1'b0; data_gnt1_i = 1'b0;
        drive(1'b1, 17'h0_0001, 32'h11, 1'b1);
        checks++; if (data_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_gnt got %b exp 0", data_gnt_o); end
        tick();
        drive(1'b0, 17'h0, 32'h0, 1'b0);
        tick();
        checks++; if ({data_req0_o, data_req1_o, proto_err_o} !== 3'b000)
            begin errors++; $display("FAIL rst_req_err got %b exp 000", {data_req0_o, data_req1_o, proto_err_o}); end
        checks++; if ({data_AUX0_o, data_ID0_o, data_last0_o, data_AUX1_o, data_ID1_o, data_last1_o} !== '0)
            begin errors++; $display("FAIL rst_payload got %h/%h exp 0/0", data_AUX0_o, data_AUX1_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_beat();
        data_gnt1_i = 1'b1;
        drive(1'b1, 17'h1_0005, 32'hA5, 1'b1);
        checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL t1_gnt got %b exp 1", data_gnt_o); end
        tick();
        drive(1'b0, 17'h0, 32'h0, 1'b0);
        checks++; if ({data_req1_o, data_ID1_o, data_AUX1_o, data_last1_o, data_req0_o} !== {1'b1, 16'h0005, 32'hA5, 1'b1, 1'b0})
            begin errors++; $display("FAIL t1_out1 got req1=%b id=%h aux=%h last=%b req0=%b exp 1 0005 a5 1 0",
                data_req1_o, data_ID1_o, data_AUX1_o, data_last1_o, data_req0_o); end
        tick();
        checks++; if (data_req1_o !== 1'b0) begin errors++; $display("FAIL t1_drained got %b exp 0", data_req1_o); end
        data_gnt1_i = 1'b0;
    endtask

    task automatic test_burst();
        data_gnt0_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, 17'h0_0010 + 17'(b), 32'h200 + 32'(b), b == 3);
            checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL t2_gnt%0d got %b exp 1", b, data_gnt_o); end
            tick();
            checks++; if ({data_req0_o, data_AUX0_o, data_ID0_o, data_last0_o, data_req1_o} !==
                          {1'b1, 32'h200 + 32'(b), 16'h0010 + 16'(b), b == 3, 1'b0})
                begin errors++; $display("FAIL t2_beat%0d got req0=%b aux=%h id=%h last=%b req1=%b", b,
                    data_req0_o, data_AUX0_o, data_ID0_o, data_last0_o, data_req1_o); end
        end
        drive(1'b0, 17'h0, 32'h0, 1'b0);
        tick();
        checks++; if (data_req0_o !== 1'b0) begin errors++; $display("FAIL t2_drained got %b exp 0", data_req0_o); end
    endtask

    task automatic test_fill_drain();
        data_gnt0_i = 1'b0;
        for (int b = 1; b <= 3; b++) begin
            drive(1'b1, 17'h0_0030, 32'h300 + 32'(b), 1'b1);
            checks++; if (data_gnt_o !== (b < 3)) begin errors++; $display("FAIL t3_gnt%0d got %b exp %b", b, data_gnt_o, b < 3); end
            if (b < 3) tick();
        end
        data_gnt0_i = 1'b1;
        #1;
        checks++; if ({data_gnt_o, data_AUX0_o} !== {1'b0, 32'h301})
            begin errors++; $display("FAIL t3_full_pop got gnt=%b aux=%h exp 0 301", data_gnt_o, data_AUX0_o); end
        tick();
        checks++; if ({data_gnt_o, data_AUX0_o} !== {1'b1, 32'h302})
            begin errors++; $display("FAIL t3_second got gnt=%b aux=%h exp 1 302", data_gnt_o, data_AUX0_o); end
        tick();
        drive(1'b0, 17'h0, 32'h0, 1'b0);
        checks++; if ({data_req0_o, data_AUX0_o} !== {1'b1, 32'h303})
            begin errors++; $display("FAIL t3_third got req=%b aux=%h exp 1 303", data_req0_o, data_AUX0_o); end
        tick();
        checks++; if (data_req0_o !== 1'b0) begin errors++; $display("FAIL t3_drained got %b exp 0", data_req0_o); end
    endtask

    task automatic test_hol_blocking();
        data_gnt0_i = 1'b0; data_gnt1_i = 1'b0;
        drive(1'b1, 17'h0_0040, 32'h401, 1'b1); tick();
        drive(1'b1, 17'h0_0040, 32'h402, 1'b1); tick();
        drive(1'b1, 17'h1_0041, 32'h411, 1'b1);
        checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL t4_gnt1 got %b exp 1", data_gnt_o); end
        tick();
        checks++; if ({data_req1_o, data_AUX1_o} !== {1'b1, 32'h411})
            begin errors++; $display("FAIL t4_out1 got req=%b aux=%h exp 1 411", data_req1_o, data_AUX1_o); end
        drive(1'b1, 17'h0_0040, 32'h403, 1'b1);
        checks++; if (data_gnt_o !== 1'b0) begin errors++; $display("FAIL t4_stall got %b exp 0", data_gnt_o); end
        tick();
        checks++; if ({data_gnt_o, data_AUX0_o} !== {1'b0, 32'h401})
            begin errors++; $display("FAIL t4_stall2 got gnt=%b aux=%h exp 0 401", data_gnt_o, data_AUX0_o); end
        data_gnt0_i = 1'b1;
        tick();
        #1;
        checks++; if ({data_gnt_o, data_AUX0_o} !== {1'b1, 32'h402})
            begin errors++; $display("FAIL t4_resume got gnt=%b aux=%h exp 1 402", data_gnt_o, data_AUX0_o); end
        tick();
        drive(1'b0, 17'h0, 32'h0, 1'b0);
        checks++; if (data_AUX0_o !== 32'h403) begin errors++; $display("FAIL t4_last got %h exp 403", data_AUX0_o); end
        data_gnt1_i = 1'b1;
        tick();
        checks++; if ({data_req0_o, data_req1_o} !== 2'b00)
            begin errors++; $display("FAIL t4_drained got %b exp 00", {data_req0_o, data_req1_o}); end
        data_gnt1_i = 1'b0;
    endtask

    task automatic test_proto_err();
        data_gnt0_i = 1'b1;
        drive(1'b1, 17'h0_0050, 32'h501, 1'b0); tick();
        drive(1'b1, 17'h1_0050, 32'h502, 1'b0);
        checks++; if ({data_gnt_o, proto_err_o} !== 2'b10)
            begin errors++; $display("FAIL t5_pre got gnt=%b err=%b exp 1 0", data_gnt_o, proto_err_o); end
        tick();
        checks++; if ({data_req0_o, data_AUX0_o, data_req1_o, proto_err_o} !== {1'b1, 32'h502, 1'b0, 1'b1})
            begin errors++; $display("FAIL t5_locked got req0=%b aux=%h req1=%b err=%b exp 1 502 0 1",
                data_req0_o, data_AUX0_o, data_req1_o, proto_err_o); end
        drive(1'b1, 17'h0_0050, 32'h503, 1'b1); tick();
        drive(1'b0, 17'h0, 32'h0, 1'b0);
        tick(); tick();
        checks++; if ({proto_err_o, data_req0_o} !== 2'b10)
            begin errors++; $display("FAIL t5_sticky got err=%b req0=%b exp 1 0", proto_err_o, data_req0_o); end
    endtask

    task automatic test_reset_mid_burst();
        data_gnt0_i = 1'b0; data_gnt1_i = 1'b0;
        drive(1'b1, 17'h0_0060, 32'h601, 1'b0); tick();
        drive(1'b1, 17'h0_0060, 32'h602, 1'b0); tick();
        drive(1'b0, 17'h0, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        checks++; if ({data_req0_o, data_gnt_o, data_AUX0_o} !== {1'b0, 1'b0, 32'h0})
            begin errors++; $display("FAIL t6_in_rst got req0=%b gnt=%b aux=%h exp 0 0 0", data_req0_o, data_gnt_o, data_AUX0_o); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if ({data_req0_o, proto_err_o} !== 2'b00)
            begin errors++; $display("FAIL t6_after_rst got req0=%b err=%b exp 0 0", data_req0_o, proto_err_o); end
        data_gnt1_i = 1'b1;
        drive(1'b1, 17'h1_0042, 32'h606, 1'b1);
        checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL t6_gnt got %b exp 1", data_gnt_o); end
        tick();
        drive(1'b0, 17'h0, 32'h0, 1'b0);
        checks++; if ({data_req1_o, data_ID1_o, data_AUX1_o, data_req0_o, proto_err_o} !== {1'b1, 16'h0042, 32'h606, 1'b0, 1'b0})
            begin errors++; $display("FAIL t6_route got req1=%b id=%h aux=%h req0=%b err=%b exp 1 0042 606 0 0",
                data_req1_o, data_ID1_o, data_AUX1_o, data_req0_o, proto_err_o); end
    endtask

    initial begin
        rst = 1'b1;
        data_req_i = 1'b0; data_ID_i = '0; data_AUX_i = '0; data_last_i = 1'b0;
        data_gnt0_i = 1'b0; data_gnt1_i = 1'b0;
        test_reset();
        test_single_beat();
        test_burst();
        test_fill_drain();
        test_hol_blocking();
        test_proto_err();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
